// File: rtl/draw_rect_drag_if.sv
// VGA stream bundle: timing counters, blanking, syncs and pixel colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
  modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
endinterface

// File: rtl/draw_rect_drag.sv
// Draws N_RECT filled rectangles over a VGA stream (2-cycle latency); the left mouse button drags them.
// Optional feature: define DRAW_RECT_BORDER_EN to outline the dragged rectangle in white.
module draw_rect_drag #(
  parameter int N_RECT   = 4,
  parameter int RECT_W   = 64,
  parameter int RECT_H   = 64,
  parameter int X_MAX    = 1023,
  parameter int Y_MAX    = 767,
  parameter int INIT_X0  = 64,
  parameter int INIT_GAP = 16,
  parameter int INIT_Y   = 64,
  localparam int SEL_W   = (N_RECT > 1) ? $clog2(N_RECT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_if.slave                 vga_in,
  vga_if.master                vga_out,
  input  logic [11:0]          xpos,
  input  logic [11:0]          ypos,
  input  logic                 mouse_left,
  input  logic [N_RECT*12-1:0] rect_rgb,
  output logic                 drag_active,
  output logic [SEL_W-1:0]     sel_idx
);
  localparam logic [12:0] X_LIM = 13'(X_MAX - RECT_W + 1);
  localparam logic [12:0] Y_LIM = 13'(Y_MAX - RECT_H + 1);

  typedef enum logic {IDLE, DRAG} state_t;

  state_t           state_q, state_d;
  logic             ml_q, ml_d;
  logic             drag_active_q, drag_active_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [11:0]      dx_q, dx_d, dy_q, dy_d;
  logic [11:0]      pos_x_q [N_RECT];
  logic [11:0]      pos_x_d [N_RECT];
  logic [11:0]      pos_y_q [N_RECT];
  logic [11:0]      pos_y_d [N_RECT];
  logic [11:0]      rect_col [N_RECT];

  logic [10:0]       s1_hcount_q, s1_vcount_q;
  logic              s1_hblnk_q, s1_vblnk_q, s1_hsync_q, s1_vsync_q;
  logic [11:0]       s1_rgb_q;
  logic [N_RECT-1:0] s1_mask_q, s1_mask_d;

  logic [10:0] s2_hcount_q, s2_vcount_q;
  logic        s2_hblnk_q, s2_vblnk_q, s2_hsync_q, s2_vsync_q;
  logic [11:0] s2_rgb_q, s2_rgb_d;

  logic [N_RECT-1:0]  ptr_hit;
  logic               press, frame_edge;
  logic [SEL_W-1:0]   ptr_top, pix_top;
  logic signed [12:0] raw_x, raw_y;
  logic [11:0]        clamp_x, clamp_y;
  logic [11:0]        sel_colour;

  genvar gi;
  generate
    for (gi = 0; gi < N_RECT; gi++) begin : g_rect
      logic [12:0] x_lo, x_hi, y_lo, y_hi;
      assign x_lo = {1'b0, pos_x_q[gi]};
      assign y_lo = {1'b0, pos_y_q[gi]};
      assign x_hi = x_lo + 13'(RECT_W - 1);
      assign y_hi = y_lo + 13'(RECT_H - 1);
      assign rect_col[gi] = rect_rgb[gi*12 +: 12];

      assign ptr_hit[gi] = ({1'b0, xpos} >= x_lo) && ({1'b0, xpos} <= x_hi) &&
                           ({1'b0, ypos} >= y_lo) && ({1'b0, ypos} <= y_hi);
      assign s1_mask_d[gi] = ({2'b0, vga_in.hcount} >= x_lo) && ({2'b0, vga_in.hcount} <= x_hi) &&
                             ({2'b0, vga_in.vcount} >= y_lo) && ({2'b0, vga_in.vcount} <= y_hi);

      always_ff @(posedge clk) begin
        if (rst) begin
          pos_x_q[gi] <= 12'(INIT_X0 + gi * (RECT_W + INIT_GAP));
          pos_y_q[gi] <= 12'(INIT_Y);
        end else begin
          pos_x_q[gi] <= pos_x_d[gi];
          pos_y_q[gi] <= pos_y_d[gi];
        end
      end
    end
  endgenerate

  // Highest index wins both for mouse selection and for drawing.
  always_comb begin
    ptr_top = '0;
    pix_top = '0;
    for (int i = 0; i < N_RECT; i++) begin
      if (ptr_hit[i])   ptr_top = SEL_W'(i);
      if (s1_mask_q[i]) pix_top = SEL_W'(i);
    end
  end

  always_comb begin
    press      = mouse_left & ~ml_q;
    frame_edge = vga_in.vblnk & ~s1_vblnk_q;
    raw_x      = $signed({1'b0, xpos}) - $signed({1'b0, dx_q});
    raw_y      = $signed({1'b0, ypos}) - $signed({1'b0, dy_q});
    clamp_x    = raw_x[11:0];
    clamp_y    = raw_y[11:0];
    if (raw_x < 0)                    clamp_x = '0;
    else if (raw_x > $signed(X_LIM))  clamp_x = X_LIM[11:0];
    if (raw_y < 0)                    clamp_y = '0;
    else if (raw_y > $signed(Y_LIM))  clamp_y = Y_LIM[11:0];

    ml_d    = mouse_left;
    state_d = state_q;
    sel_d   = sel_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    case (state_q)
      IDLE: begin
        if (press && (|ptr_hit)) begin
          state_d = DRAG;
          sel_d   = ptr_top;
          dx_d    = xpos - pos_x_q[ptr_top];
          dy_d    = ypos - pos_y_q[ptr_top];
        end
      end
      DRAG: begin
        // Release takes priority over a coincident frame boundary.
        if (!mouse_left) begin
          state_d = IDLE;
        end else if (frame_edge) begin
          pos_x_d[sel_q] = clamp_x;
          pos_y_d[sel_q] = clamp_y;
        end
      end
      default: state_d = IDLE;
    endcase
    drag_active_d = (state_d == DRAG);
  end

`ifdef DRAW_RECT_BORDER_EN
  logic [11:0] off_x, off_y;
  logic        on_border;
  always_comb begin
    off_x      = {1'b0, s1_hcount_q} - pos_x_q[sel_q];
    off_y      = {1'b0, s1_vcount_q} - pos_y_q[sel_q];
    on_border  = (off_x < 12'd2) || (off_x >= 12'(RECT_W - 2)) ||
                 (off_y < 12'd2) || (off_y >= 12'(RECT_H - 2));
    sel_colour = on_border ? 12'hFFF : rect_col[sel_q];
  end
`else
  assign sel_colour = rect_col[sel_q];
`endif

  // The rectangle being dragged is drawn above all others.
  always_comb begin
    s2_rgb_d = s1_rgb_q;
    if (!(s1_hblnk_q || s1_vblnk_q)) begin
      if (drag_active_q && s1_mask_q[sel_q]) s2_rgb_d = sel_colour;
      else if (|s1_mask_q)                   s2_rgb_d = rect_col[pix_top];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ml_q          <= 1'b0;
      drag_active_q <= 1'b0;
      sel_q         <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      s1_hcount_q   <= '0;
      s1_vcount_q   <= '0;
      s1_hblnk_q    <= 1'b0;
      s1_vblnk_q    <= 1'b0;
      s1_hsync_q    <= 1'b0;
      s1_vsync_q    <= 1'b0;
      s1_rgb_q      <= '0;
      s1_mask_q     <= '0;
      s2_hcount_q   <= '0;
      s2_vcount_q   <= '0;
      s2_hblnk_q    <= 1'b0;
      s2_vblnk_q    <= 1'b0;
      s2_hsync_q    <= 1'b0;
      s2_vsync_q    <= 1'b0;
      s2_rgb_q      <= '0;
    end else begin
      state_q       <= state_d;
      ml_q          <= ml_d;
      drag_active_q <= drag_active_d;
      sel_q         <= sel_d;
      dx_q          <= dx_d;
      dy_q          <= dy_d;
      s1_hcount_q   <= vga_in.hcount;
      s1_vcount_q   <= vga_in.vcount;
      s1_hblnk_q    <= vga_in.hblnk;
      s1_vblnk_q    <= vga_in.vblnk;
      s1_hsync_q    <= vga_in.hsync;
      s1_vsync_q    <= vga_in.vsync;
      s1_rgb_q      <= vga_in.rgb;
      s1_mask_q     <= s1_mask_d;
      s2_hcount_q   <= s1_hcount_q;
      s2_vcount_q   <= s1_vcount_q;
      s2_hblnk_q    <= s1_hblnk_q;
      s2_vblnk_q    <= s1_vblnk_q;
      s2_hsync_q    <= s1_hsync_q;
      s2_vsync_q    <= s1_vsync_q;
      s2_rgb_q      <= s2_rgb_d;
    end
  end

  assign vga_out.hcount = s2_hcount_q;
  assign vga_out.vcount = s2_vcount_q;
  assign vga_out.hblnk  = s2_hblnk_q;
  assign vga_out.vblnk  = s2_vblnk_q;
  assign vga_out.hsync  = s2_hsync_q;
  assign vga_out.vsync  = s2_vsync_q;
  assign vga_out.rgb    = s2_rgb_q;
  assign drag_active    = drag_active_q;
  assign sel_idx        = sel_q;
endmodule

// File: doc/draw_rect_drag.md
# draw_rect_drag

Parametrised successor of the single-square draw/control pair: a 65 MHz VGA pipeline stage that draws `N_RECT` filled rectangles over the incoming `vga_if` stream and lets the user drag any of them with the left mouse button. It sits between `draw_bg` and `draw_mouse`. It takes mouse coordinates already re-registered into the pixel clock domain, and it owns all rectangle positions internally.

## Interface
Parameters:
- `N_RECT`, 4: number of rectangles, 1..8; a higher index is drawn on top.
- `RECT_W`, 64: rectangle width in pixels.
- `RECT_H`, 64: rectangle height in pixels.
- `X_MAX`, 1023: last visible column.
- `Y_MAX`, 767: last visible row.
- `INIT_X0`, 64: reset x of rectangle 0.
- `INIT_GAP`, 16: reset horizontal gap between rectangles.
- `INIT_Y`, 64: reset y of all rectangles.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: pixel clock, 65 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `vga_in`, in, `vga_if`: hcount, vcount, hblnk, vblnk, hsync, vsync, rgb[11:0].
- `vga_out`, out, `vga_if`: same fields, delayed 2 cycles.
- `xpos`, in, 12: mouse x, synchronous to `clk`.
- `ypos`, in, 12: mouse y, synchronous to `clk`.
- `mouse_left`, in, 1: left button level, synchronous to `clk`.
- `rect_rgb`, in, `N_RECT*12`: fill colour; rectangle i uses bits [12i+11:12i].
- `drag_active`, out, 1: high while in DRAG.
- `sel_idx`, out, `$clog2(N_RECT)` (min 1): index of the held rectangle.

## Operation
- Rectangle i reset position:
  - x_i = `INIT_X0` + i·(`RECT_W`+`INIT_GAP`)
  - y_i = `INIT_Y`
  - Positions are 12-bit registers.
- Button edge: `ml_q` is `mouse_left` delayed 1 cycle; `press` = `mouse_left & ~ml_q`.
- State machine with two states, IDLE and DRAG:
  - IDLE -> DRAG on `press`, only if (xpos, ypos) hits a rectangle.
    - Hit condition: x_i ≤ xpos ≤ x_i+RECT_W−1 and y_i ≤ ypos ≤ y_i+RECT_H−1.
    - If several rectangles are hit, the highest index wins.
    - Latch `sel_idx`, dx = xpos−x_i, dy = ypos−y_i.
  - IDLE stays IDLE if `press` hits nothing.
  - A held button never selects; a new `press` edge is required.
  - DRAG -> IDLE whenever `mouse_left` = 0; the rectangle keeps its last position.
- Position update happens only in DRAG, on the frame-boundary cycle (vblnk rising edge of `vga_in`):
  - Compute x = xpos−dx and y = ypos−dy in 13-bit signed arithmetic.
  - Clamp x to [0, X_MAX−RECT_W+1] and y to [0, Y_MAX−RECT_H+1].
  - Write the result to the selected rectangle only.
  - Because updates happen only in vblank, rectangles never tear.
- Draw pipeline:
  - Stage 1: register the `vga_in` fields plus an `N_RECT`-bit per-pixel inside mask.
  - Stage 2 colour choice:
    - During blanking (hblnk | vblnk), rgb passes through.
    - Otherwise, if drag_active and the selected rectangle is hit, use its colour.
    - Otherwise, use the colour of the highest hit index.
    - Otherwise, pass the stage-1 rgb through.

## Timing
- Reset values:
  - All `vga_out` fields 0.
  - `drag_active` 0, `sel_idx` 0.
  - State IDLE, `ml_q` 0, positions at reset values.
- Latency from `vga_in` to `vga_out`: exactly 2 cycles; all sync and blank fields are delayed equally.
- `drag_active` and `sel_idx` are valid 1 cycle after the `press` cycle, and drop 1 cycle after `mouse_left` falls.
- Simultaneous events:
  - `press` on a frame-boundary cycle: selection is taken; the first move happens at the next frame boundary.
  - Release on a frame-boundary cycle: release wins; no update is applied.
- Reset mid-drag: return to IDLE and restore all positions next cycle.

## Configuration
- `DRAW_RECT_BORDER_EN` defined:
  - While drag_active, pixels of the selected rectangle within 2 pixels of its edge are drawn as 12'hFFF.
  - The interior keeps the rectangle's own colour.
- Undefined: no border logic; the selected rectangle is drawn in its own colour only.

## Test plan
All scenarios use the default parameters, so rectangles start at x = 64/144/224/304, y = 64.

- Reset, then scan a frame -> pixel (64,64) = rect_rgb[0]; (127,127) = rect_rgb[0]; (128,64) = vga_in rgb; `vga_out` equals `vga_in` delayed exactly 2 cycles.
- Press at (150,70) -> drag_active=1, sel_idx=1 next cycle. Move the mouse to (400,300) and wait one vblank rising edge -> rect1 at (394,294).
- Drag rect0 toward (0,0) and toward (2000,2000) -> position clamps to (0,0), then to (960,704).
- Hold the button over empty space at (10,10), then move onto rect2 -> no selection. Release, then press at (230,70) -> sel_idx=2.
- Overlap test: drag rect3 so it overlaps rect0, release, press in the overlap -> sel_idx=3. Press and release on the same frame-boundary cycle -> no move.
- Assert rst during DRAG -> next cycle drag_active=0 and all positions are back to their reset values.
